// File: rtl/multi_byte_sub_add_seq_pkg.sv
// Shared definitions for the multi-byte add/subtract sequencer:
// controller state encoding and the default operand width in bytes.
package multi_byte_sub_add_seq_pkg;

  localparam int unsigned NBYTES_DEF = 4;
  localparam int unsigned IDXW_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/multi_byte_sub_add_seq_if.sv
// Host-facing handshake and operand/result bus of the sequencer.
// The host drives through master; the sequencer receives through slave.
interface multi_byte_sub_add_seq_if #(
  parameter int unsigned NBYTES = 4
);
  logic                  START;
  logic [8*NBYTES-1:0]   OP_A;
  logic [8*NBYTES-1:0]   OP_B;
  logic                  SUB_ADD;
  logic                  B_CIN;
  logic                  BUSY;
  logic                  DONE;
  logic [8*NBYTES-1:0]   RESULT;
  logic                  B_COUT;

  modport master (
    output START, OP_A, OP_B, SUB_ADD, B_CIN,
    input  BUSY, DONE, RESULT, B_COUT
  );

  modport slave (
    input  START, OP_A, OP_B, SUB_ADD, B_CIN,
    output BUSY, DONE, RESULT, B_COUT
  );

endinterface

// File: rtl/multi_byte_sub_add_seq_byte_select_mux.sv
// Picks byte idx of both latched operands for the 8-bit stage; outputs zero
// when disabled so the stage sees quiet inputs outside an operation.
module byte_select_mux #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned IDXW   = 4
) (
  input  logic                en,
  input  logic [IDXW-1:0]     idx,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  output logic [7:0]          byte_a,
  output logic [7:0]          byte_b
);

  always_comb begin
    byte_a = '0;
    byte_b = '0;
    if (en) begin
      for (int unsigned k = 0; k < NBYTES; k++) begin
        if (idx == IDXW'(k)) begin
          byte_a = op_a[8*k +: 8];
          byte_b = op_b[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/multi_byte_sub_add_seq.sv
// Runs an NBYTES-wide add/subtract through an external combinational 8-bit
// stage, one byte per clock, LSB first, with a start/busy/done handshake.
module multi_byte_sub_add_seq
  import multi_byte_sub_add_seq_pkg::*;
#(
  parameter int unsigned NBYTES = NBYTES_DEF,
  parameter int unsigned IDXW   = IDXW_DEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  multi_byte_sub_add_seq_if.slave    host,
  output logic [7:0]                 STG_A,
  output logic [7:0]                 STG_B,
  output logic                       STG_CIN,
  output logic                       STG_SUB_ADD,
  input  logic [7:0]                 STG_D_S,
  input  logic                       STG_COUT
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_t              state;
  logic [IDXW-1:0]     idx;
  logic                carry;
  logic                sub_q;
  logic [8*NBYTES-1:0] op_a_q;
  logic [8*NBYTES-1:0] op_b_q;
  logic                run;

  assign run = (state == RUN);

  byte_select_mux #(
    .NBYTES (NBYTES),
    .IDXW   (IDXW)
  ) u_byte_select_mux (
    .en     (run),
    .idx    (idx),
    .op_a   (op_a_q),
    .op_b   (op_b_q),
    .byte_a (STG_A),
    .byte_b (STG_B)
  );

  always_comb begin
    STG_CIN     = run & carry;
    STG_SUB_ADD = run & sub_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      sub_q       <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      host.BUSY   <= 1'b0;
      host.DONE   <= 1'b0;
      host.RESULT <= '0;
      host.B_COUT <= 1'b0;
    end else begin
      host.DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (host.START) begin
            op_a_q    <= host.OP_A;
            op_b_q    <= host.OP_B;
            sub_q     <= host.SUB_ADD;
            carry     <= host.B_CIN;
            idx       <= '0;
            host.BUSY <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          for (int unsigned k = 0; k < NBYTES; k++) begin
            if (idx == IDXW'(k)) host.RESULT[8*k +: 8] <= STG_D_S;
          end
          carry <= STG_COUT;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // Final carry and DONE are registered on the last RUN edge so
            // both are already valid throughout the FIN cycle.
            host.B_COUT <= STG_COUT;
            host.DONE   <= 1'b1;
            host.BUSY   <= 1'b0;
            state       <= FIN;
          end
        end
        FIN: begin
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_byte_sub_add_seq.sv
// Directed bench for multi_byte_sub_add_seq (NBYTES=4) with a behavioural
// 8-bit add/subtract stage and a wide reference for the bulk vectors.
module tb_multi_byte_sub_add_seq;

  localparam int unsigned NB = 4;

  logic       CLK;
  logic       RST;
  logic [7:0] stg_a, stg_b, stg_d_s;
  logic       stg_cin, stg_sub_add, stg_cout;

  int checks   = 0;
  int failures = 0;

  multi_byte_sub_add_seq_if #(.NBYTES(NB)) bus ();

  multi_byte_sub_add_seq #(
    .NBYTES (NB),
    .IDXW   (4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .host        (bus),
    .STG_A       (stg_a),
    .STG_B       (stg_b),
    .STG_CIN     (stg_cin),
    .STG_SUB_ADD (stg_sub_add),
    .STG_D_S     (stg_d_s),
    .STG_COUT    (stg_cout)
  );

  // 8-bit stage: subtract gives borrow-out when a < b + borrow-in
  always_comb begin
    stg_d_s  = '0;
    stg_cout = 1'b0;
    if (stg_sub_add) begin
      stg_d_s  = stg_a - stg_b - {7'b0, stg_cin};
      stg_cout = ({1'b0, stg_a} < ({1'b0, stg_b} + {8'b0, stg_cin}));
    end else begin
      {stg_cout, stg_d_s} = {1'b0, stg_a} + {1'b0, stg_b} + {8'b0, stg_cin};
    end
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c);
    bus.OP_A    = a;
    bus.OP_B    = b;
    bus.SUB_ADD = s;
    bus.B_CIN   = c;
    bus.START   = 1'b1;
    tick();
    bus.START   = 1'b0;
  endtask

  // Caller is in RUN cycle start_n; returns once DONE is seen or budget expires.
  task automatic wait_done(input int start_n, input string tag);
    int n;
    n = start_n;
    while (bus.DONE !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(NB + 1));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c,
                        input logic [31:0] exp_r, input logic exp_c);
    launch(a, b, s, c);
    wait_done(1, tag);
    check({tag, "_result"}, 64'(bus.RESULT), 64'(exp_r));
    check({tag, "_cout"},   64'(bus.B_COUT), 64'(exp_c));
    tick();
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs, rc;
    logic [32:0] ref_v;
    logic        saw_done;

    RST         = 1'b1;
    bus.START   = 1'b0;
    bus.OP_A    = '0;
    bus.OP_B    = '0;
    bus.SUB_ADD = 1'b0;
    bus.B_CIN   = 1'b0;
    tick();
    tick();
    check("rst_busy",    64'(bus.BUSY),   64'(0));
    check("rst_done",    64'(bus.DONE),   64'(0));
    check("rst_result",  64'(bus.RESULT), 64'(0));
    check("rst_cout",    64'(bus.B_COUT), 64'(0));
    check("rst_stg_a",   64'(stg_a),      64'(0));
    check("rst_stg_b",   64'(stg_b),      64'(0));
    check("rst_stg_cin", 64'(stg_cin),    64'(0));
    check("rst_stg_sub", 64'(stg_sub_add),64'(0));
    RST = 1'b0;
    tick();

    // First op checked by hand, including stage drive in RUN cycle 1
    launch(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    check("run1_busy",  64'(bus.BUSY), 64'(1));
    check("run1_stg_a", 64'(stg_a),    64'(8'hFF));
    check("run1_stg_b", 64'(stg_b),    64'(8'h01));
    wait_done(1, "add_ff_1");
    check("add_ff_1_result",    64'(bus.RESULT), 64'(32'h0000_0100));
    check("add_ff_1_cout",      64'(bus.B_COUT), 64'(0));
    check("add_ff_1_busy_done", 64'(bus.BUSY),   64'(0));
    tick();
    check("done_one_cycle", 64'(bus.DONE), 64'(0));

    run_op("add_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
    run_op("sub_100_1",  32'h0000_0100, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_00FF, 1'b0);
    run_op("sub_0_1",    32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
    run_op("sub_bin",    32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    run_op("add_mixed",  32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0, 32'h0000_0000, 1'b1);

    // START during RUN and FIN is ignored; START held into IDLE is accepted
    launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    tick();
    bus.OP_A    = 32'hFFFF_FFFF;
    bus.OP_B    = 32'h0000_0001;
    bus.SUB_ADD = 1'b1;
    bus.START   = 1'b1;
    tick();
    bus.START   = 1'b0;
    wait_done(3, "ign_start");
    check("ign_start_result", 64'(bus.RESULT), 64'(32'h2345_6789));
    check("ign_start_cout",   64'(bus.B_COUT), 64'(0));
    bus.OP_A    = 32'h8000_0000;
    bus.OP_B    = 32'h0000_0001;
    bus.SUB_ADD = 1'b1;
    bus.B_CIN   = 1'b1;
    bus.START   = 1'b1;
    tick();
    check("fin_start_ignored", 64'(bus.BUSY), 64'(0));
    tick();
    bus.START = 1'b0;
    check("b2b_busy", 64'(bus.BUSY), 64'(1));
    wait_done(1, "b2b");
    check("b2b_result", 64'(bus.RESULT), 64'(32'h7FFF_FFFE));
    check("b2b_cout",   64'(bus.B_COUT), 64'(0));
    tick();

    // Reset in RUN cycle 3 aborts without a DONE pulse
    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_busy",   64'(bus.BUSY),   64'(0));
    check("abort_done",   64'(bus.DONE),   64'(0));
    check("abort_result", 64'(bus.RESULT), 64'(0));
    check("abort_cout",   64'(bus.B_COUT), 64'(0));
    check("abort_stg_a",  64'(stg_a),      64'(0));
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw_done |= bus.DONE;
    end
    check("abort_no_done", 64'(saw_done), 64'(0));
    run_op("post_abort", 32'h0001_0000, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0000_0001, 1'b0);

    // Bulk vectors against a wide reference, modulo 2**32
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      if (rs) ref_v = {1'b0, ra} - {1'b0, rb} - {32'b0, rc};
      else    ref_v = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      run_op("bulk", ra, rb, rs, rc, ref_v[31:0], ref_v[32]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_byte_sub_add_seq.md
Name: multi_byte_sub_add_seq

Overview:
Sequential controller that runs wide (NBYTES x 8-bit) add/subtract operations through the existing 8-bit subtractor/adder stage, one byte per clock, LSB first. It sits directly upstream and downstream of that stage. It drives the stage's A, B, B_CIN and SUB_ADD inputs. It captures the stage's D_S and B_COUT outputs into a wide result register and a carry/borrow register. A start/busy/done handshake faces the host.

Parameters:
NBYTES, 4, number of 8-bit limbs per operand (legal range 2..16)
IDXW, 4, width of the byte index counter; must satisfy 2**IDXW >= NBYTES

Ports:
CLK  input  1  rising-edge clock; single clock domain
RST  input  1  synchronous, active-high reset
START  input  1  request a new operation; sampled only in IDLE
OP_A  input  8*NBYTES  minuend / augend; latched on accepted START
OP_B  input  8*NBYTES  subtrahend / addend; latched on accepted START
SUB_ADD  input  1  1 = subtract, 0 = add; latched on accepted START
B_CIN  input  1  initial carry-in (add) or borrow-in (subtract); latched on accepted START
BUSY  output  1  high from the cycle after an accepted START until DONE is asserted
DONE  output  1  one-cycle pulse; RESULT and B_COUT are valid when it is high
RESULT  output  8*NBYTES  wide difference/sum; held until the next accepted START
B_COUT  output  1  final carry-out / borrow-out; held with RESULT
STG_A  output  8  byte to the stage A input
STG_B  output  8  byte to the stage B input
STG_CIN  output  1  to the stage B_CIN input
STG_SUB_ADD  output  1  to the stage SUB_ADD input
STG_D_S  input  8  from the stage D_S output
STG_COUT  input  1  from the stage B_COUT output

Behaviour:
- Clock and reset: one clock (CLK); RST is synchronous and active-high. All state updates on the CLK rising edge.
- Reset values: state=IDLE; BUSY=0; DONE=0; RESULT=0; B_COUT=0; idx=0; carry register=0; operand registers=0.
- STG_* outputs during reset and IDLE: STG_A=0, STG_B=0, STG_CIN=0, STG_SUB_ADD=0.
- Stage assumption: the stage is purely combinational. Its result is consumed in the same cycle it is presented.
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1 latches OP_A, OP_B, SUB_ADD, B_CIN; loads carry register with B_CIN; sets idx=0; moves to RUN.
  - START=0: stay in IDLE.
- RUN, each cycle:
  - Drive STG_A=opA[idx], STG_B=opB[idx], STG_CIN=carry register, STG_SUB_ADD=latched op.
  - At the clock edge: RESULT byte idx <= STG_D_S; carry register <= STG_COUT; idx <= idx+1.
  - When idx==NBYTES-1, also go to FIN.
- FIN (one cycle): DONE=1; B_COUT <= carry register; BUSY=0 in this cycle; next state IDLE.
- Latency: with START accepted at edge 0, RUN occupies cycles 1..NBYTES and DONE is high in cycle NBYTES+1. Back-to-back issue is possible one cycle after DONE.
- BUSY is high in RUN only.
- START while in RUN or FIN: ignored, with no queueing. Operand inputs are don't-care outside accepted START.
- Byte ordering: RESULT bits [8k+7:8k] are written while idx==k; untouched bytes keep their previous value until written.
- RESULT is not cleared on START; it is undefined-but-stable until DONE. The bench checks it only at DONE.
- Arithmetic: subtract semantics follow the stage (borrow-out=1 when minuend < subtrahend+borrow-in). No signed overflow flag.
- RST mid-operation: abort immediately; all registers return to reset values; no DONE pulse.
- RST and START in the same cycle: RST wins.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'b00, RUN=2'b01, FIN=2'b10) and the NBYTES default.
- The byte-select mux (opA/opB indexed by idx) is natural as one sub-module, byte_select_mux, parameterised by NBYTES.
- The 8-bit stage is not instantiated inside this block. The system top wires this block to it.

Test Plan:
- Add 0x000000FF + 0x00000001, B_CIN=0 -> RESULT=0x00000100, B_COUT=0, DONE exactly 5 cycles after START.
- Add 0xFFFFFFFF + 0x00000000, B_CIN=1 -> RESULT=0x00000000, B_COUT=1 (full ripple across all 4 bytes).
- Subtract 0x00000100 - 0x00000001, B_CIN=0 -> RESULT=0x000000FF, B_COUT=0; subtract 0x00000000 - 0x00000001 -> RESULT=0xFFFFFFFF, B_COUT=1.
- START pulsed again at cycle 2 of an operation with different operands -> ignored; the first result is delivered unchanged; a new START in the cycle after DONE is accepted.
- RST asserted in cycle 3 of RUN -> next cycle state=IDLE, BUSY=0, RESULT=0, B_COUT=0, no DONE pulse; a subsequent operation completes correctly.
- Randomised 1000 ops with NBYTES=2 and NBYTES=4, stage model in the bench -> RESULT/B_COUT match a wide reference add/subtract mod 2**(8*NBYTES).
